// File: rtl/sccb_mode_sequencer.sv
// sccb_mode_sequencer: walks one of several ROM register tables and issues each
// {addr,data} write to a downstream SCCB master over valid/ready. Table entries
// whose address equals DELAY_ADDR are inline waits of data*TICKS_PER_UNIT cycles.
// NACKed writes are re-issued up to RETRIES times before an error is flagged.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, mode_i       start pulse and table select (sampled in IDLE only)
//   abort_i               stop the running sequence and return to IDLE
//   busy_o                sequence in progress
//   done_o, err_o         1-cycle completion / error pulses
//   err_idx_o             op index of the last error (cleared on next start)
//   wr_valid_o/addr/data  write request to the SCCB master
//   wr_ready_i            master accepts the request
//   wr_done_i, wr_nack_i  transaction finished pulse, qualified by NACK
module sccb_mode_sequencer #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned MODES          = 4,
  parameter int unsigned MAX_OPS        = 64,
  parameter bit [MODES-1:0][MAX_OPS-1:0][ADDR_W+DATA_W-1:0] MODE_ROM = '0,
  parameter bit [MODES-1:0][31:0] MODE_OPS = '0,
  parameter bit [ADDR_W-1:0]    DELAY_ADDR     = ADDR_W'(16'hffff),
  parameter int unsigned        TICKS_PER_UNIT = 100000,
  parameter int unsigned        RETRIES        = 3,
  localparam int unsigned MODE_W = (MODES > 1) ? $clog2(MODES) : 1,
  localparam int unsigned IDX_W  = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [IDX_W-1:0]  err_idx_o,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic              wr_ready_i,
  input  logic              wr_done_i,
  input  logic              wr_nack_i
);

  localparam int unsigned     OP_W    = ADDR_W + DATA_W;
  localparam int unsigned     RTY_W   = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  // Longest wait is the largest data value times the tick count per unit.
  localparam longint unsigned DLY_MAX = ((64'd1 << DATA_W) - 64'd1) * 64'(TICKS_PER_UNIT);
  localparam int unsigned     DLY_W   = (DLY_MAX > 64'd1) ? $clog2(DLY_MAX + 64'd1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_RESP,
    S_DELAY
  } state_t;

  state_t state_q, state_d;

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [DLY_W-1:0]  dly_q, dly_d;

  logic              busy_d, done_d, err_d, wr_valid_d;
  logic [IDX_W-1:0]  err_idx_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;
  logic [31:0]       sel_ops, cur_ops;
  logic              abort_act, start_act, mode_ok, sel_empty, is_delay, last_op;
  logic              accept, resp_ok, resp_nack, retry_left, dly_end;

  // Decoded events and table lookups shared by both combinational processes.
  always_comb begin
    op         = MODE_ROM[mode_q][idx_q];
    op_addr    = op[OP_W-1:DATA_W];
    op_data    = op[DATA_W-1:0];
    is_delay   = (op_addr == DELAY_ADDR);
    sel_ops    = MODE_OPS[mode_i];
    cur_ops    = MODE_OPS[mode_q];
    mode_ok    = (32'(mode_i) < MODES);
    sel_empty  = (sel_ops == 32'd0);
    abort_act  = abort_i && (state_q != S_IDLE);
    // Abort on the same cycle as start swallows the start.
    start_act  = start_i && !abort_i;
    // Stop at the table's own length or at the last ROM slot, whichever is first.
    last_op    = ((32'(idx_q) + 32'd1) >= cur_ops) || (32'(idx_q) == (MAX_OPS - 1));
    accept     = wr_valid_o && wr_ready_i;
    resp_ok    = wr_done_i && !wr_nack_i;
    resp_nack  = wr_done_i && wr_nack_i;
    retry_left = (32'(retry_q) < RETRIES);
    dly_end    = (dly_q <= DLY_W'(1));
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort_act) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_act && mode_ok && !sel_empty) state_d = S_FETCH;
        end
        S_FETCH: begin
          state_d = is_delay ? S_DELAY : S_ISSUE;
        end
        S_ISSUE: begin
          if (accept) state_d = S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          if (resp_ok) begin
            state_d = last_op ? S_IDLE : S_FETCH;
          end else if (resp_nack) begin
            state_d = retry_left ? S_ISSUE : S_IDLE;
          end
        end
        S_DELAY: begin
          if (dly_end) state_d = last_op ? S_IDLE : S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    busy_d     = busy_o;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_idx_d  = err_idx_o;
    wr_valid_d = wr_valid_o;
    wr_addr_d  = wr_addr_o;
    wr_data_d  = wr_data_o;
    mode_d     = mode_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    dly_d      = dly_q;

    if (abort_act) begin
      busy_d     = 1'b0;
      wr_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_act) begin
            err_idx_d = '0;
            if (!mode_ok) begin
              err_d = 1'b1;
            end else begin
              mode_d = mode_i;
              idx_d  = '0;
              if (sel_empty) done_d = 1'b1;
              else           busy_d = 1'b1;
            end
          end
        end
        S_FETCH: begin
          retry_d = '0;
          if (is_delay) begin
            dly_d = DLY_W'(op_data) * DLY_W'(TICKS_PER_UNIT);
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = op_addr;
            wr_data_d  = op_data;
          end
        end
        S_ISSUE: begin
          if (accept) wr_valid_d = 1'b0;
        end
        S_WAIT_RESP: begin
          if (resp_ok) begin
            if (last_op) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (resp_nack) begin
            if (retry_left) begin
              // Same op again: address and data are still held in the output regs.
              retry_d    = retry_q + RTY_W'(1);
              wr_valid_d = 1'b1;
            end else begin
              err_d     = 1'b1;
              err_idx_d = idx_q;
              busy_d    = 1'b0;
            end
          end
        end
        S_DELAY: begin
          if (dly_end) begin
            if (last_op) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
        default: begin
          busy_d     = 1'b0;
          wr_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_idx_o  <= '0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      mode_q     <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      dly_q      <= '0;
    end else begin
      busy_o     <= busy_d;
      done_o     <= done_d;
      err_o      <= err_d;
      err_idx_o  <= err_idx_d;
      wr_valid_o <= wr_valid_d;
      wr_addr_o  <= wr_addr_d;
      wr_data_o  <= wr_data_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      dly_q      <= dly_d;
    end
  end

endmodule

// File: tb/tb_sccb_mode_sequencer.sv
// tb_sccb_mode_sequencer: directed checks of sccb_mode_sequencer against a
// behavioural SCCB slave with configurable ready stall, NACK count and response.
module tb_sccb_mode_sequencer;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MODES   = 5;
  localparam int unsigned MAX_OPS = 8;
  localparam int unsigned TPU     = 10;
  localparam int unsigned RETRIES = 3;
  localparam int unsigned OP_W    = ADDR_W + DATA_W;

  // Per-mode tables, op 0 in the least significant slot.
  localparam bit [MAX_OPS*OP_W-1:0] M0 = {{3{24'h0}}, 24'h3104_04, 24'hffff_00,
                                          24'h3103_03, 24'hffff_05, 24'h3008_82};
  localparam bit [MAX_OPS*OP_W-1:0] M1 = {{5{24'h0}}, 24'h3037_15, 24'h3036_54, 24'h3035_11};
  localparam bit [MAX_OPS*OP_W-1:0] M2 = {{4{24'h0}}, 24'h4003_04, 24'h4002_03,
                                          24'h4001_02, 24'h4000_01};
  localparam bit [MAX_OPS*OP_W-1:0] M3 = '0;
  localparam bit [MAX_OPS*OP_W-1:0] M4 = {{7{24'h0}}, 24'h5000_aa};
  localparam bit [MODES-1:0][MAX_OPS-1:0][OP_W-1:0] ROM = {M4, M3, M2, M1, M0};
  localparam bit [MODES-1:0][31:0] OPS = {32'd1, 32'd0, 32'd4, 32'd3, 32'd5};

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  mode_i;
  logic        abort_i;
  logic        busy_o, done_o, err_o;
  logic [2:0]  err_idx_o;
  logic        wr_valid_o;
  logic [15:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        wr_ready_i, wr_done_i, wr_nack_i;

  sccb_mode_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MODES(MODES), .MAX_OPS(MAX_OPS),
    .MODE_ROM(ROM), .MODE_OPS(OPS), .DELAY_ADDR(16'hffff),
    .TICKS_PER_UNIT(TPU), .RETRIES(RETRIES)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_idx_o(err_idx_o), .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i), .wr_done_i(wr_done_i),
    .wr_nack_i(wr_nack_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  bit [23:0] log_op[$];
  int        log_cyc[$];

  // Slave configuration written by the main sequence only.
  int          cfg_stall = 0;
  int          cfg_nack  = 0;
  logic [15:0] cfg_nack_addr = 16'h0;
  bit          cfg_resp  = 1'b1;
  int          cfg_gen   = 0;
  int          inj_gen   = 0;

  // Slave-private state.
  int          s_gen = 0, s_inj = 0, s_stall = 0, s_nack = 0;
  bit          s_acc = 1'b0;
  logic [15:0] s_acc_addr = 16'h0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (done_o) done_cnt = done_cnt + 1;
    if (err_o)  err_cnt  = err_cnt + 1;
  end

  // SCCB slave: logs accepted writes, answers with wr_done_i one cycle later.
  initial begin
    wr_ready_i = 1'b0;
    wr_done_i  = 1'b0;
    wr_nack_i  = 1'b0;
    forever begin
      @(negedge clk_i);
      s_acc      = wr_valid_o && wr_ready_i;
      s_acc_addr = wr_addr_o;
      if (s_acc) begin
        log_op.push_back({wr_addr_o, wr_data_o});
        log_cyc.push_back(cyc);
      end
      @(posedge clk_i);
      #1;
      if (cfg_gen != s_gen) begin
        s_gen   = cfg_gen;
        s_stall = cfg_stall;
        s_nack  = cfg_nack;
      end
      wr_done_i = 1'b0;
      wr_nack_i = 1'b0;
      if (s_acc && cfg_resp) begin
        wr_done_i = 1'b1;
        if (s_nack > 0 && s_acc_addr == cfg_nack_addr) begin
          wr_nack_i = 1'b1;
          s_nack    = s_nack - 1;
        end
      end
      if (inj_gen != s_inj) begin
        s_inj     = inj_gen;
        wr_done_i = 1'b1;
      end
      if (wr_valid_o && s_stall > 0) begin
        wr_ready_i = 1'b0;
        s_stall    = s_stall - 1;
      end else begin
        wr_ready_i = wr_valid_o;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < log_op.size()) return 32'(log_op[i]);
    return 32'hdead_beef;
  endfunction

  function automatic int gap_at(input int i);
    if (i + 1 < log_cyc.size()) return log_cyc[i+1] - log_cyc[i];
    return -1;
  endfunction

  task automatic set_slave(input int stall, input logic [15:0] naddr, input int nack, input bit resp);
    cfg_stall     = stall;
    cfg_nack_addr = naddr;
    cfg_nack      = nack;
    cfg_resp      = resp;
    cfg_gen       = cfg_gen + 1;
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk_i);
  endtask

  // Raise start for one cycle; returns at the negedge of the first cycle after it.
  task automatic start_mode(input logic [2:0] m);
    start_i = 1'b1;
    mode_i  = m;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // n = 1 on the cycle right after start was sampled.
  task automatic wait_end(input int budget, output int n);
    n = 1;
    while (!(done_o || err_o) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk("end_seen", 32'(done_o || err_o), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!wr_valid_o && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    chk("valid_seen", 32'(wr_valid_o), 32'd1);
  endtask

  initial begin
    int n, base, d0, e0;
    rst_i   = 1'b1;
    start_i = 1'b0;
    mode_i  = 3'd0;
    abort_i = 1'b0;
    tick(3);

    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    chk("rst_eidx",  32'(err_idx_o), 32'd0);
    chk("rst_valid", 32'(wr_valid_o), 32'd0);
    chk("rst_addr",  32'(wr_addr_o), 32'd0);
    chk("rst_data",  32'(wr_data_o), 32'd0);
    rst_i = 1'b0;
    tick(2);

    // Mode 1, immediate ready/done: 3 writes, 3 cycles each, done on cycle 10.
    set_slave(0, 16'h0, 0, 1'b1);
    base = log_op.size(); d0 = done_cnt; e0 = err_cnt;
    start_mode(3'd1);
    chk("m1_busy_c1", 32'(busy_o), 32'd1);
    wait_end(200, n);
    chk("m1_latency", 32'(n), 32'd10);
    chk("m1_done", 32'(done_o), 32'd1);
    chk("m1_busy_at_done", 32'(busy_o), 32'd0);
    tick(2);
    chk("m1_nwr", 32'(log_op.size() - base), 32'd3);
    chk("m1_op0", log_at(base), 32'h303511);
    chk("m1_op1", log_at(base + 1), 32'h303654);
    chk("m1_op2", log_at(base + 2), 32'h303715);
    chk("m1_ndone", 32'(done_cnt - d0), 32'd1);
    chk("m1_nerr", 32'(err_cnt - e0), 32'd0);

    // Ready held low 10 cycles: request must stay put.
    set_slave(10, 16'h0, 0, 1'b1);
    base = log_op.size(); d0 = done_cnt;
    start_mode(3'd1);
    wait_valid(20);
    for (int k = 0; k < 10; k++) begin
      chk("stall_hold", {7'd0, wr_valid_o, wr_addr_o, wr_data_o}, {7'd0, 1'b1, 16'h3035, 8'h11});
      tick(1);
    end
    wait_end(200, n);
    tick(2);
    chk("stall_nwr", 32'(log_op.size() - base), 32'd3);
    chk("stall_op0", log_at(base), 32'h303511);
    chk("stall_op2", log_at(base + 2), 32'h303715);
    chk("stall_ndone", 32'(done_cnt - d0), 32'd1);

    // Single-op table.
    set_slave(0, 16'h0, 0, 1'b1);
    base = log_op.size();
    start_mode(3'd4);
    wait_end(50, n);
    chk("m4_latency", 32'(n), 32'd4);
    chk("m4_done", 32'(done_o), 32'd1);
    tick(2);
    chk("m4_op0", log_at(base), 32'h5000aa);

    // Op 2 NACKed four times: three re-issues then error.
    set_slave(0, 16'h4002, 4, 1'b1);
    base = log_op.size(); d0 = done_cnt; e0 = err_cnt;
    start_mode(3'd2);
    wait_end(300, n);
    chk("nk_latency", 32'(n), 32'd16);
    chk("nk_err", 32'(err_o), 32'd1);
    chk("nk_done", 32'(done_o), 32'd0);
    chk("nk_busy", 32'(busy_o), 32'd0);
    chk("nk_eidx", 32'(err_idx_o), 32'd2);
    tick(5);
    chk("nk_eidx_held", 32'(err_idx_o), 32'd2);
    chk("nk_nwr", 32'(log_op.size() - base), 32'd6);
    chk("nk_op1", log_at(base + 1), 32'h400102);
    for (int k = 2; k < 6; k++) chk("nk_retry_op", log_at(base + k), 32'h400203);
    chk("nk_ndone", 32'(done_cnt - d0), 32'd0);
    chk("nk_nerr", 32'(err_cnt - e0), 32'd1);

    // Out-of-range mode: error only, index cleared.
    base = log_op.size(); d0 = done_cnt; e0 = err_cnt;
    start_mode(3'd5);
    wait_end(10, n);
    chk("bad_latency", 32'(n), 32'd1);
    chk("bad_err", 32'(err_o), 32'd1);
    chk("bad_eidx", 32'(err_idx_o), 32'd0);
    chk("bad_busy", 32'(busy_o), 32'd0);
    tick(3);
    chk("bad_nwr", 32'(log_op.size() - base), 32'd0);
    chk("bad_ndone", 32'(done_cnt - d0), 32'd0);
    chk("bad_nerr", 32'(err_cnt - e0), 32'd1);

    // Empty table: done only, never busy.
    d0 = done_cnt; e0 = err_cnt;
    start_mode(3'd3);
    wait_end(10, n);
    chk("empty_latency", 32'(n), 32'd1);
    chk("empty_done", 32'(done_o), 32'd1);
    chk("empty_busy", 32'(busy_o), 32'd0);
    tick(1);
    chk("empty_busy_after", 32'(busy_o), 32'd0);
    tick(2);
    chk("empty_ndone", 32'(done_cnt - d0), 32'd1);
    chk("empty_nerr", 32'(err_cnt - e0), 32'd0);

    // Two NACKs then ACK: sequence completes.
    set_slave(0, 16'h4002, 2, 1'b1);
    base = log_op.size(); d0 = done_cnt; e0 = err_cnt;
    start_mode(3'd2);
    wait_end(300, n);
    chk("nr_latency", 32'(n), 32'd17);
    chk("nr_done", 32'(done_o), 32'd1);
    tick(2);
    chk("nr_nwr", 32'(log_op.size() - base), 32'd6);
    chk("nr_op4", log_at(base + 4), 32'h400203);
    chk("nr_op5", log_at(base + 5), 32'h400304);
    chk("nr_nerr", 32'(err_cnt - e0), 32'd0);

    // Start while busy is ignored.
    set_slave(0, 16'h0, 0, 1'b1);
    base = log_op.size(); d0 = done_cnt;
    start_mode(3'd1);
    start_i = 1'b1;
    mode_i  = 3'd2;
    tick(1);
    start_i = 1'b0;
    wait_end(200, n);
    tick(2);
    chk("bs_nwr", 32'(log_op.size() - base), 32'd3);
    chk("bs_op1", log_at(base + 1), 32'h303654);
    chk("bs_ndone", 32'(done_cnt - d0), 32'd1);

    // Abort while a request is stalled in ISSUE.
    set_slave(100, 16'h0, 0, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    start_mode(3'd4);
    wait_valid(20);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    chk("abi_valid", 32'(wr_valid_o), 32'd0);
    chk("abi_busy", 32'(busy_o), 32'd0);
    tick(3);
    chk("abi_npulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

    // Abort in WAIT_RESP, late wr_done_i must be dropped.
    set_slave(0, 16'h0, 0, 1'b0);
    base = log_op.size(); d0 = done_cnt; e0 = err_cnt;
    start_mode(3'd1);
    wait_valid(20);
    tick(1);
    abort_i = 1'b1;
    inj_gen = inj_gen + 1;
    tick(1);
    abort_i = 1'b0;
    chk("abw_busy", 32'(busy_o), 32'd0);
    chk("abw_valid", 32'(wr_valid_o), 32'd0);
    tick(4);
    chk("abw_busy_late", 32'(busy_o), 32'd0);
    chk("abw_nwr", 32'(log_op.size() - base), 32'd1);
    chk("abw_ndone", 32'(done_cnt - d0), 32'd0);
    chk("abw_nerr", 32'(err_cnt - e0), 32'd0);

    // Mode 0 from idx 0: 5-unit delay (50 cycles) and zero delay (1 cycle).
    set_slave(0, 16'h0, 0, 1'b1);
    base = log_op.size(); d0 = done_cnt;
    start_mode(3'd0);
    wait_end(300, n);
    chk("dl_latency", 32'(n), 32'd63);
    tick(2);
    chk("dl_nwr", 32'(log_op.size() - base), 32'd3);
    chk("dl_op0", log_at(base), 32'h300882);
    chk("dl_op1", log_at(base + 1), 32'h310303);
    chk("dl_op2", log_at(base + 2), 32'h310404);
    chk("dl_gap5", 32'(gap_at(base)), 32'd54);
    chk("dl_gap0", 32'(gap_at(base + 1)), 32'd5);
    chk("dl_ndone", 32'(done_cnt - d0), 32'd1);

    // Reset mid-sequence: outputs clear, no pulses.
    d0 = done_cnt; e0 = err_cnt;
    start_mode(3'd1);
    wait_valid(20);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    chk("mr_valid", 32'(wr_valid_o), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    tick(4);
    chk("mr_npulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
